// File: rtl/lsu_if.sv
// LSU bus interfaces: execute-side request/completion and memory bus.
// Ports: lsu_req_if (req_*, ls_*), lsu_mem_if (mem_*); lsu is req slave, mem master.
interface lsu_req_if #(
  parameter int DATA_LEN = 32
);
  logic                req_valid;
  logic                req_ready;
  logic                req_load;
  logic                req_store;
  logic [1:0]          req_size;
  logic                req_sign;
  logic [DATA_LEN-1:0] req_addr;
  logic [DATA_LEN-1:0] req_wdata;
  logic                ls_valid;
  logic                ls_ready;
  logic [DATA_LEN-1:0] load_data;
  logic                ls_err;

  modport master (
    output req_valid, req_load, req_store,
    output req_size, req_sign, req_addr,
    output req_wdata, ls_ready,
    input  req_ready, ls_valid, load_data,
    input  ls_err
  );

  modport slave (
    input  req_valid, req_load, req_store,
    input  req_size, req_sign, req_addr,
    input  req_wdata, ls_ready,
    output req_ready, ls_valid, load_data,
    output ls_err
  );
endinterface

interface lsu_mem_if #(
  parameter int DATA_LEN = 32
);
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [DATA_LEN-1:0] mem_addr;
  logic                mem_wen;
  logic [DATA_LEN-1:0] mem_wdata;
  logic [3:0]          mem_wmask;
  logic                mem_rsp_valid;
  logic [DATA_LEN-1:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_wen,
    output mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_wen,
    input  mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid,
    output mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one op in flight, valid/ready memory bus, load align/extend.
// Ports: clk, rst_n (async low), req (lsu_req_if.slave), mem (lsu_mem_if.master).
module lsu #(
  parameter int DATA_LEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_req_if.slave   req,
  lsu_mem_if.master  mem
);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DONE
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_e              state_q, state_d;
  logic                ld_q, ld_d;
  logic                sign_q, sign_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          off_q, off_d;
  logic [DATA_LEN-1:0] addr_q, addr_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  logic [DATA_LEN-1:0] ldata_q, ldata_d;
  logic [3:0]          wmask_q, wmask_d;
  logic                wen_q, wen_d;
  logic                err_q, err_d;

  logic                accept;
  logic                misalign;
  logic [DATA_LEN-1:0] wrep;
  logic [3:0]          smask;
  logic [DATA_LEN-1:0] sh;
  logic [DATA_LEN-1:0] ext;

  assign accept = (state_q == IDLE) && req.req_valid
                && (req.req_load || req.req_store);

  // Alignment check, store lane replication and strobes.
  always_comb begin
    misalign = 1'b0;
    wrep     = req.req_wdata;
    smask    = 4'b1111;
    unique case (req.req_size)
      SZ_B: begin
        wrep  = {4{req.req_wdata[7:0]}};
        smask = 4'b0001 << req.req_addr[1:0];
      end
      SZ_H: begin
        misalign = req.req_addr[0];
        wrep     = {2{req.req_wdata[15:0]}};
        smask    = 4'b0011 << {req.req_addr[1], 1'b0};
      end
      SZ_W: misalign = |req.req_addr[1:0];
      default: misalign = 1'b1;
    endcase
  end

  // Legal halves have off[0]=0, so one shift serves all sizes.
  always_comb begin
    sh  = mem.mem_rdata >> {off_q, 3'b000};
    ext = sh;
    unique case (size_q)
      SZ_B: ext = {{(DATA_LEN-8){sign_q & sh[7]}}, sh[7:0]};
      SZ_H: ext = {{(DATA_LEN-16){sign_q & sh[15]}}, sh[15:0]};
      default: ext = sh;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    sign_d  = sign_q;
    size_d  = size_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    wmask_d = wmask_q;
    wen_d   = wen_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ld_d    = req.req_load;
          sign_d  = req.req_sign;
          size_d  = req.req_size;
          off_d   = req.req_addr[1:0];
          addr_d  = {req.req_addr[DATA_LEN-1:2], 2'b00};
          wdata_d = wrep;
          wmask_d = req.req_load ? 4'b0000 : smask;
          wen_d   = ~req.req_load;
          err_d   = misalign;
          ldata_d = '0;
          state_d = misalign ? DONE : REQ;
        end
      end
      REQ: begin
        if (mem.mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem.mem_rsp_valid) begin
          ldata_d = ld_q ? ext : '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (req.ls_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ld_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
      wmask_q <= 4'b0000;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      sign_q  <= sign_d;
      size_q  <= size_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      wmask_q <= wmask_d;
      wen_q   <= wen_d;
      err_q   <= err_d;
    end
  end

  assign req.req_ready     = (state_q == IDLE);
  assign req.ls_valid      = (state_q == DONE);
  assign req.load_data     = ldata_q;
  assign req.ls_err        = err_q;
  assign mem.mem_req_valid = (state_q == REQ);
  assign mem.mem_addr      = addr_q;
  assign mem.mem_wen       = wen_q;
  assign mem.mem_wdata     = wdata_q;
  assign mem.mem_wmask     = wmask_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: byte-level reference memory, random ops and knobs.
// Drives req side from tasks; a negedge process models memory and checks outputs.
module tb_lsu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_req_if #(.DATA_LEN(32)) rq ();
  lsu_mem_if #(.DATA_LEN(32)) mb ();

  lsu #(.DATA_LEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rq),
    .mem   (mb)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic [3:0]  wmask;
  } bus_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } cmp_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bus_t exp_bus[$];
  cmp_t exp_cmp[$];
  bus_t h;
  cmp_t c;

  logic [7:0]  ref_mem [256];
  logic [31:0] mem_words [64];

  int rdy_wait = 0;
  int lsr_wait = 0;
  int rsp_dly = 1;
  int acc_at = 0;
  int rsp_at = 0;
  int pend = 0;
  logic [31:0] pend_data = '0;
  int rdy_cnt = 0;
  int lsr_cnt = 0;
  bit prev_mrv = 0;
  bit prev_lsv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] w);
    int b;
    b = int'(a[7:0]) & ~3;
    mem_words[a[7:2]] = w;
    for (int i = 0; i < 4; i++) ref_mem[b + i] = w[8*i +: 8];
  endtask

  task automatic issue(input bit ld, input bit st, input logic [1:0] sz,
                       input bit sg, input logic [31:0] a,
                       input logic [31:0] wd);
    int n;
    int b;
    bit err;
    logic [31:0] v;
    bus_t eb;
    cmp_t ec;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || ((a % n) != 0);
    b   = int'(a[7:0]);
    v   = '0;
    if (ld && !err) begin
      for (int i = 0; i < n; i++)
        v |= 32'(ref_mem[(b + i) & 255]) << (8 * i);
      if (sg && n < 4 && v[8*n-1])
        v |= 32'hFFFF_FFFF << (8 * n);
    end
    eb.addr  = a - (a % 4);
    eb.wen   = !ld;
    eb.wdata = (n == 1) ? {24'h0, wd[7:0]} * 32'h0101_0101 :
               (n == 2) ? {16'h0, wd[15:0]} * 32'h0001_0001 : wd;
    eb.wmask = ld ? 4'h0 : 4'((1 << n) - 1) << (a % 4);
    @(negedge clk);
    rq.req_valid = 1'b1;
    rq.req_load  = ld;
    rq.req_store = st;
    rq.req_size  = sz;
    rq.req_sign  = sg;
    rq.req_addr  = a;
    rq.req_wdata = wd;
    for (int i = 0; i < 100 && !rq.req_ready; i++) @(negedge clk);
    chk("req_ready idle", rq.req_ready, 1);
    if (ld || st) begin
      if (!err) exp_bus.push_back(eb);
      ec.data = v;
      ec.err  = err;
      exp_cmp.push_back(ec);
      acc_at = cyc + 1;
      if (!ld && !err)
        for (int i = 0; i < n; i++) ref_mem[(b + i) & 255] = wd[8*i +: 8];
    end
    @(posedge clk);
    #1;
    rq.req_valid = 1'b0;
    rq.req_load  = 1'($urandom);
    rq.req_store = 1'($urandom);
    rq.req_addr  = $urandom;
    rq.req_wdata = $urandom;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 300 && (exp_cmp.size() != 0 || exp_bus.size() != 0); i++)
      @(negedge clk);
    chk("drain", exp_cmp.size() + exp_bus.size(), 0);
  endtask

  // Memory responder and output monitor share one process so that
  // the ready decisions and the queue pops happen in a fixed order.
  initial begin : bfm
    mb.mem_req_ready = 1'b0;
    mb.mem_rsp_valid = 1'b0;
    mb.mem_rdata     = '0;
    rq.ls_ready      = 1'b0;
    forever begin
      @(negedge clk);
      mb.mem_rsp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mb.mem_rsp_valid = 1'b1;
          mb.mem_rdata     = pend_data;
          rsp_at           = cyc + 1;
        end
      end
      if (!rst_n) begin
        mb.mem_req_ready = 1'b0;
        rq.ls_ready      = 1'b0;
        rdy_cnt  = 0;
        lsr_cnt  = 0;
        prev_mrv = 0;
        prev_lsv = 0;
      end else begin
        mb.mem_req_ready = 1'b0;
        if (mb.mem_req_valid) begin
          if (!prev_mrv) chk("req latency", cyc, acc_at);
          chk("req_ready busy", rq.req_ready, 0);
          if (exp_bus.size() == 0) begin
            chk("unexpected bus req", mb.mem_req_valid, 0);
          end else begin
            h = exp_bus[0];
            chk("mem_addr", mb.mem_addr, h.addr);
            chk("mem_wen", mb.mem_wen, h.wen);
            if (h.wen) chk("mem_wdata", mb.mem_wdata, h.wdata);
            chk("mem_wmask", mb.mem_wmask, h.wmask);
            if (rdy_cnt < rdy_wait) begin
              rdy_cnt++;
              if (pend == 0 && $urandom_range(0, 2) == 0) begin
                mb.mem_rsp_valid = 1'b1;
                mb.mem_rdata     = $urandom;
              end
            end else begin
              mb.mem_req_ready = 1'b1;
              rdy_cnt = 0;
              void'(exp_bus.pop_front());
              if (mb.mem_wen)
                for (int l = 0; l < 4; l++)
                  if (mb.mem_wmask[l])
                    mem_words[mb.mem_addr[7:2]][8*l +: 8] =
                      mb.mem_wdata[8*l +: 8];
              pend_data = mem_words[mb.mem_addr[7:2]];
              pend      = rsp_dly;
            end
          end
        end
        prev_mrv = mb.mem_req_valid;
        rq.ls_ready = 1'b0;
        if (rq.ls_valid) begin
          if (exp_cmp.size() == 0) begin
            chk("unexpected ls_valid", rq.ls_valid, 0);
          end else begin
            c = exp_cmp[0];
            if (!prev_lsv)
              chk("done latency", cyc, c.err ? acc_at : rsp_at);
            chk("load_data", rq.load_data, c.data);
            chk("ls_err", rq.ls_err, c.err);
            chk("req_ready done", rq.req_ready, 0);
            if (lsr_cnt < lsr_wait) begin
              lsr_cnt++;
            end else begin
              rq.ls_ready = 1'b1;
              lsr_cnt = 0;
              void'(exp_cmp.pop_front());
            end
          end
        end
        prev_lsv = rq.ls_valid;
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, " mem_req_valid"}, mb.mem_req_valid, 0);
    chk({tag, " ls_valid"}, rq.ls_valid, 0);
    chk({tag, " ls_err"}, rq.ls_err, 0);
    chk({tag, " load_data"}, rq.load_data, 0);
    chk({tag, " mem_addr"}, mb.mem_addr, 0);
    chk({tag, " mem_wdata"}, mb.mem_wdata, 0);
    chk({tag, " mem_wmask"}, mb.mem_wmask, 0);
    chk({tag, " mem_wen"}, mb.mem_wen, 0);
    chk({tag, " req_ready"}, rq.req_ready, 1);
  endtask

  initial begin : stim
    logic [1:0]  sz;
    logic [31:0] a;
    int k;
    rq.req_valid = 1'b0;
    rq.req_load  = 1'b0;
    rq.req_store = 1'b0;
    rq.req_size  = 2'b00;
    rq.req_sign  = 1'b0;
    rq.req_addr  = '0;
    rq.req_wdata = '0;
    for (int w = 0; w < 64; w++) poke(32'(w * 4), $urandom);

    #3;
    chk_zero("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    poke(32'h100, 32'hDEAD_BEEF);
    issue(1, 0, 2'd2, 0, 32'h100, 0);
    drain();

    poke(32'h100, 32'h80FF_0000);
    issue(1, 0, 2'd0, 1, 32'h103, 0);
    drain();
    issue(1, 0, 2'd0, 0, 32'h103, 0);
    drain();

    issue(0, 1, 2'd1, 0, 32'h202, 32'h1234_ABCD);
    drain();
    issue(1, 0, 2'd2, 0, 32'h200, 0);
    drain();

    issue(1, 0, 2'd2, 0, 32'h101, 0);
    drain();
    issue(1, 0, 2'd3, 0, 32'h100, 0);
    drain();
    issue(0, 1, 2'd3, 0, 32'h104, 32'h5555_AAAA);
    drain();

    rdy_wait = 5;
    lsr_wait = 3;
    issue(1, 0, 2'd1, 1, 32'h102, 0);
    drain();
    rdy_wait = 0;
    lsr_wait = 0;

    issue(0, 0, 2'd2, 0, 32'h100, 0);
    repeat (3) @(negedge clk);
    chk("ignored req_ready", rq.req_ready, 1);
    chk("ignored mem_req_valid", mb.mem_req_valid, 0);
    chk("ignored ls_valid", rq.ls_valid, 0);

    rsp_dly = 6;
    issue(1, 0, 2'd2, 0, 32'h100, 0);
    for (int i = 0; i < 50 && exp_bus.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("mid reset");
    exp_cmp.delete();
    exp_bus.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle after stray rsp", rq.req_ready, 1);
    rsp_dly = 1;
    issue(1, 0, 2'd2, 0, 32'h100, 0);
    drain();

    repeat (200) begin
      rdy_wait = $urandom_range(0, 3);
      lsr_wait = $urandom_range(0, 3);
      rsp_dly  = $urandom_range(1, 3);
      k  = $urandom_range(0, 9);
      sz = (k < 3) ? 2'd0 : (k < 6) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      k = $urandom_range(0, 5);
      issue(k <= 3, k == 0 || k >= 4, sz, 1'($urandom), a, $urandom);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
